// File: rtl/dds_nco.sv
// Numerically controlled oscillator: phase accumulator -> phase offset -> waveform -> output register.
// Optional amplitude scaling on the output stage is built only when DDS_AMPLITUDE_EN is defined.
module dds_nco #(
  parameter int ACC_W   = 16,
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    sync_clr,
  input  logic [ACC_W-1:0]        ftw_in,
  input  logic                    ftw_load,
  input  logic [PHASE_W-1:0]      phase_off,
  input  logic [1:0]              mode,
  input  logic [7:0]              amp,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    out_valid
);

  localparam int QN = 2 ** (PHASE_W - 2);
  localparam int A  = 2 ** (OUT_W - 1) - 1;
  localparam logic [OUT_W-1:0] A_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] A_NEG = ~A_POS + 1'b1;

  // Quarter-wave entry k = round(A*sin(2*pi*(k+0.5)/2^PHASE_W)), evaluated at elaboration.
  function automatic int sine_entry(input int k);
    real x;
    real term;
    real sum;
    x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(2 ** PHASE_W);
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(real'(A) * sum + 0.5);
  endfunction

  logic [OUT_W-2:0] sine_lut [QN];

  for (genvar k = 0; k < QN; k++) begin : g_lut
    localparam int V = sine_entry(k);
    assign sine_lut[k] = V[OUT_W-2:0];
  end

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        ftw_q, ftw_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [1:0]              mode_q, mode_d;
  logic [OUT_W-1:0]        s2_q, s2_d;
  logic signed [OUT_W-1:0] smp_q, smp_d;
  logic [1:0]              fill_q, fill_d;

  // S0 / S1 / fill counter
  always_comb begin
    ftw_d   = ftw_load ? ftw_in : ftw_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    if (sync_clr) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (ena) begin
      acc_d = acc_q + ftw_q;
      if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
    end
    if (ena) begin
      phase_d = acc_q[ACC_W-1 -: PHASE_W] + phase_off;
      mode_d  = mode;
    end
  end

  // S2 waveform generation
  logic [1:0]         quad;
  logic [PHASE_W-3:0] lut_idx;
  logic [OUT_W-1:0]   sine_mag;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-2:0]   tri_t;
  logic [OUT_W-1:0]   wave;

  always_comb begin
    quad     = phase_q[PHASE_W-1 -: 2];
    lut_idx  = quad[0] ? ~phase_q[PHASE_W-3:0] : phase_q[PHASE_W-3:0];
    sine_mag = {1'b0, sine_lut[lut_idx]};
    p        = phase_q[PHASE_W-1 -: OUT_W];
    tri_t    = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
    wave     = '0;
    case (mode_q)
      2'b00:   wave = quad[1] ? ('0 - sine_mag) : sine_mag;
      2'b01:   wave = p[OUT_W-1] ? A_NEG : A_POS;
      2'b10:   wave = {~p[OUT_W-1], p[OUT_W-2:0]};
      default: wave = {~tri_t[OUT_W-2], tri_t[OUT_W-3:0], 1'b0};
    endcase
    s2_d = ena ? wave : s2_q;
  end

  // S3 output register, optionally scaled by (amp+1)/256 with floor rounding
`ifdef DDS_AMPLITUDE_EN
  logic signed [OUT_W+9:0] prod;
  logic                    unused_prod;

  always_comb begin
    prod  = $signed(s2_q) * $signed({2'b00, amp} + 10'd1);
    smp_d = ena ? prod[OUT_W+7:8] : smp_q;
  end

  assign unused_prod = ^{prod[OUT_W+9:OUT_W+8], prod[7:0]};
`else
  logic unused_amp;

  always_comb begin
    smp_d = ena ? $signed(s2_q) : smp_q;
  end

  assign unused_amp = ^amp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      ftw_q   <= '0;
      phase_q <= '0;
      mode_q  <= '0;
      s2_q    <= '0;
      smp_q   <= '0;
      fill_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      ftw_q   <= ftw_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      s2_q    <= s2_d;
      smp_q   <= smp_d;
      fill_q  <= fill_d;
    end
  end

  assign sample_out = smp_q;
  assign out_valid  = (fill_q == 2'd3);

endmodule

// File: tb/tb_dds_nco.sv
// Scoreboard bench for dds_nco at default parameters; expected samples are queued at the S1 edge
// and compared when they reach sample_out two enabled edges later.
module tb_dds_nco;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ena = 1'b1;
  logic              sync_clr = 1'b0;
  logic [15:0]       ftw_in = '0;
  logic              ftw_load = 1'b0;
  logic [7:0]        phase_off = '0;
  logic [1:0]        mode = '0;
  logic [7:0]        amp = 8'd255;
  logic signed [7:0] sample_out;
  logic              out_valid;

  dds_nco #(.ACC_W(16), .PHASE_W(8), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sync_clr(sync_clr),
    .ftw_in(ftw_in), .ftw_load(ftw_load), .phase_off(phase_off),
    .mode(mode), .amp(amp), .sample_out(sample_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] ph;
    logic [1:0] md;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [15:0] m_acc = '0;
  logic [15:0] m_ftw = '0;
  int          m_fill = 0;
  logic [7:0]  last_out = '0;

  localparam int NSP = 6;
  logic [7:0] sp_ph  [NSP] = '{8'd0, 8'd1, 8'd63, 8'd64, 8'd128, 8'd192};
  int         sp_val [NSP] = '{2, 5, 127, 127, -2, -127};

  function automatic logic [7:0] wave_ref(input logic [7:0] ph, input logic [1:0] md);
    real r;
    logic [6:0] t;
    case (md)
      2'd0: begin
        r = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(ph) + 0.5) / 256.0);
        if (r >= 0.0) return 8'($rtoi(r + 0.5));
        else return 8'(-$rtoi(-r + 0.5));
      end
      2'd1: return ph[7] ? 8'h81 : 8'h7F;
      2'd2: return ph ^ 8'h80;
      default: begin
        t = ph[7] ? ~ph[6:0] : ph[6:0];
        return {t, 1'b0} ^ 8'h80;
      end
    endcase
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] s);
`ifdef DDS_AMPLITUDE_EN
    int v;
    v = (int'($signed(s)) * (int'(amp) + 1)) >>> 8;
    return 8'(v);
`else
    return s;
`endif
  endfunction

  task automatic model_reset();
    sb.delete();
    m_acc = '0;
    m_ftw = '0;
    m_fill = 0;
    last_out = '0;
  endtask

  task automatic cyc();
    exp_t e;
    logic [7:0] want;
    if (ena) begin
      e.ph = m_acc[15:8] + phase_off;
      e.md = mode;
      e.val = wave_ref(e.ph, mode);
      sb.push_back(e);
    end
    if (sync_clr) begin
      m_acc = '0;
      m_fill = 0;
    end else if (ena) begin
      m_acc = m_acc + m_ftw;
      if (m_fill < 3) m_fill++;
    end
    if (ftw_load) m_ftw = ftw_in;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== (m_fill == 3))
      $display("FAIL out_valid: got %0b want %0b", out_valid, (m_fill == 3));
    else n_pass++;
    if (ena) begin
      if (sb.size() == 3) begin
        e = sb.pop_front();
        want = scale(e.val);
        n_checks++;
        if (sample_out !== want)
          $display("FAIL sample ph=%0d md=%0d: got %0d want %0d", e.ph, e.md,
                   sample_out, $signed(want));
        else n_pass++;
        if (e.md == 2'd0 && amp == 8'd255) begin
          for (int i = 0; i < NSP; i++) begin
            if (sp_ph[i] == e.ph) begin
              n_checks++;
              if (int'(sample_out) != sp_val[i])
                $display("FAIL sine_point ph=%0d: got %0d want %0d", e.ph, sample_out, sp_val[i]);
              else n_pass++;
            end
          end
        end
      end
    end else begin
      n_checks++;
      if (sample_out !== last_out)
        $display("FAIL hold: got %0d want %0d", sample_out, $signed(last_out));
      else n_pass++;
    end
    last_out = sample_out;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic restart(input logic [15:0] ftw);
    ftw_in = ftw;
    ftw_load = 1'b1;
    sync_clr = 1'b1;
    cyc();
    ftw_load = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic release_and_fill();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_checks++;
      if (out_valid !== (i == 3))
        $display("FAIL valid_fill edge %0d: got %0b want %0b", i, out_valid, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (sample_out !== 8'sd0) $display("FAIL reset_sample: got %0d want 0", sample_out);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid);
    else n_pass++;
    release_and_fill();
  endtask

  task automatic test_reset_mid();
    mode = 2'd1;
    restart(16'h8000);
    run(6);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sample_out !== 8'sd0) $display("FAIL midreset_sample: got %0d want 0", sample_out);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midreset_valid: got %0b want 0", out_valid);
    else n_pass++;
    release_and_fill();
  endtask

  task automatic test_sine();
    mode = 2'd0;
    phase_off = 8'h00;
    restart(16'h0100);
    run(262);
  endtask

  task automatic test_square();
    mode = 2'd1;
    restart(16'h8000);
    run(10);
    phase_off = 8'h80;
    run(10);
    phase_off = 8'h00;
    run(4);
  endtask

  task automatic test_saw_tri();
    mode = 2'd2;
    restart(16'h0100);
    run(262);
    mode = 2'd3;
    phase_off = 8'h37;
    run(5);
    phase_off = 8'h00;
    run(262);
  endtask

  task automatic test_clr_hold();
    mode = 2'd2;
    restart(16'h0100);
    run(12);
    ftw_in = 16'h0200;
    ftw_load = 1'b1;
    sync_clr = 1'b1;
    cyc();
    ftw_load = 1'b0;
    sync_clr = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL clr_valid: got %0b want 0", out_valid);
    else n_pass++;
    run(8);
    ena = 1'b0;
    ftw_in = 16'h1234;
    ftw_load = 1'b1;
    cyc();
    ftw_load = 1'b0;
    run(4);
    ena = 1'b1;
    run(10);
    ena = 1'b0;
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    run(2);
    ena = 1'b1;
    run(8);
  endtask

  task automatic test_amp();
    logic [7:0] hi;
    logic [7:0] lo;
    mode = 2'd1;
    restart(16'h8000);
    amp = 8'd127;
    run(4);
`ifdef DDS_AMPLITUDE_EN
    hi = 8'd63;
    lo = 8'hC0;
`else
    hi = 8'd127;
    lo = 8'h81;
`endif
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (sample_out !== hi && sample_out !== lo)
        $display("FAIL amp127: got %0d want %0d or %0d", sample_out, $signed(hi), $signed(lo));
      else n_pass++;
    end
    amp = 8'd255;
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (sample_out !== 8'd127 && sample_out !== 8'h81)
        $display("FAIL amp255: got %0d want 127 or -127", sample_out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sine();
    test_square();
    test_saw_tri();
    test_clr_hold();
    test_reset_mid();
    test_amp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
